// File: rtl/det_sched_pkg.sv
// rtl/det_sched_pkg.sv - shared state encoding and sizing for the frame scheduler
package det_sched_pkg;

    localparam int NREQ = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // A zero-length request still streams one bit.
    function automatic logic [3:0] eff_len(input logic [3:0] l);
        return (l == 4'd0) ? 4'd1 : l;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - four-way round-robin pick starting after the last winner
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] last_granted,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    logic [1:0] k;
    logic       found;

    always_comb begin
        gnt   = 4'd0;
        idx   = 2'd0;
        k     = 2'd0;
        found = 1'b0;
        // i == 4 wraps back to last_granted itself, searched last.
        for (int i = 1; i <= 4; i++) begin
            k = last_granted + 2'(i);
            if (!found && req[k]) begin
                found  = 1'b1;
                idx    = k;
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/det_sched.sv
// rtl/det_sched.sv - time-shares one serial detector among four frame requesters
module det_sched #(
    parameter int NREQ = det_sched_pkg::NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [3:0]      frame_len,
    input  logic [NREQ-1:0] bit_in,
    output logic [NREQ-1:0] gnt,
    output logic            stream,
    output logic            det_rst,
    output logic            det_x,
    input  logic            det_y,
    output logic            done,
    output logic [1:0]      done_id,
    output logic [3:0]      hit_cnt,
    output logic            busy
);

    import det_sched_pkg::*;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] arb_gnt;
    logic [1:0] arb_idx;
    logic [1:0] last_granted;
    logic [1:0] cur_id;
    logic [3:0] len;
    logic [3:0] scnt;
    logic [3:0] hits;

    rr_arb4 u_arb (
        .req          (req),
        .last_granted (last_granted),
        .gnt          (arb_gnt),
        .idx          (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|req) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_STREAM;
            ST_STREAM: if (scnt == len) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stream  = (state == ST_STREAM);
        det_rst = (state == ST_CLEAR);
        done    = (state == ST_DONE);
        busy    = (state != ST_IDLE);
        det_x   = (state == ST_STREAM) ? bit_in[cur_id] : 1'b0;
    end

    // DRAIN sees det_y for the last streamed bit, so the result is folded in there.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= '0;
            last_granted <= 2'd3;
            cur_id       <= 2'd0;
            len          <= 4'd0;
            scnt         <= 4'd0;
            hits         <= 4'd0;
            done_id      <= 2'd0;
            hit_cnt      <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt          <= arb_gnt;
                        cur_id       <= arb_idx;
                        last_granted <= arb_idx;
                        len          <= eff_len(frame_len);
                    end
                end
                ST_CLEAR: begin
                    scnt <= 4'd1;
                    hits <= 4'd0;
                end
                ST_STREAM: begin
                    scnt <= scnt + 4'd1;
                    if (det_y) hits <= hits + 4'd1;
                end
                ST_DRAIN: begin
                    done_id <= cur_id;
                    hit_cnt <= hits + {3'd0, det_y};
                end
                ST_DONE: gnt <= '0;
                default: ;
            endcase
        end
    end

endmodule
